// File: rtl/ff_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ff_pipe
// Description : Elastic pipeline register of DEPTH stages, WIDTH bits each,
//               with a valid bit per stage. A valid/ready handshake is used on
//               both sides. Empty stages absorb bubbles even while downstream
//               is stalled. Synchronous flush and an occupancy count are also
//               provided.
// Ports       : clk      - clock; all state updates on the rising edge
//               reset    - synchronous, active-high; dominates everything
//               flush    - synchronous clear of every stage
//               data_i   - input word
//               valid_i  - data_i is valid
//               ready_o  - pipe accepts data_i this cycle
//               data_o   - output word (last stage)
//               valid_o  - data_o is valid
//               ready_i  - downstream accepts data_o this cycle
//               count_o  - number of valid stages, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module ff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CW-1:0]    count_o
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // adv[k]: stage k may load from its upstream neighbour this cycle.
  // adv[DEPTH] is the downstream ready.
  logic [DEPTH:0]   adv;
  logic             accept;
  logic             emit;

  // The advance chain ripples from the output back to the input, so a hole
  // anywhere in the pipe lets everything upstream of it move forward.
  always_comb begin
    adv        = '0;
    adv[DEPTH] = ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k] = !v_q[k] || adv[k+1];
    end
  end

  assign ready_o = adv[0] & ~flush;
  assign valid_o = v_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];
  assign count_o = count_q;
  assign accept  = valid_i & ready_o;
  assign emit    = v_q[DEPTH-1] & ready_i;

  always_comb begin
    v_d     = v_q;
    data_d  = data_q;
    count_d = count_q;
    if (flush) begin
      // Whatever sits on the output in this cycle is discarded, not emitted.
      v_d     = '0;
      count_d = '0;
    end else begin
      if (adv[0]) begin
        v_d[0] = valid_i;
        // Input data is only captured when it is actually accepted.
        if (valid_i) begin
          data_d[0] = data_i;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k]) begin
          v_d[k] = v_q[k-1];
          if (v_q[k-1]) begin
            data_d[k] = data_q[k-1];
          end
        end
      end
      count_d = count_q + CW'(accept) - CW'(emit);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ff_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ff_pipe
// Description : Self-checking bench for ff_pipe (WIDTH=8, DEPTH=4). Accepted
//               words are queued as expected output; an independent monitor
//               pops and compares on every output handshake. Directed checks
//               cover reset, stall, bubble collapse, flush and reset recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ff_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic             flush;
  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic [CW-1:0]    count_o;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q [$];

  ff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .count_o (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every real output handshake must match the oldest accepted word.
  always @(negedge clk) begin
    if (!reset && !flush && valid_o && ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL emit_unexpected: got 0x%0h expected no output", data_o);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (data_o !== e) begin
          errors++;
          $display("FAIL emit_data: got 0x%0h expected 0x%0h", data_o, e);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush   = f;
  endtask

  // Finish the current cycle: record accepted input, then move past the edge.
  task automatic step();
    @(negedge clk);
    #1;
    if (reset || flush) exp_q.delete();
    else if (valid_i && ready_o) exp_q.push_back(data_i);
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [WIDTH-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, base + WIDTH'(i), 1'b0, 1'b0);
      step();
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_data_o",  32'(data_o),  32'd0);
    chk("rst_count_o", 32'(count_o), 32'd0);
    chk("rst_ready_o", 32'(ready_o), 32'd1);

    // 1: streaming 0x01..0x10, latency 4, count steady at 4
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, WIDTH'(i), 1'b1, 1'b0);
      step();
      if (i == 3) chk("t1_valid_before_latency", 32'(valid_o), 32'd0);
      if (i == 4) chk("t1_first_out", 32'(data_o), 32'h01);
      if (i >= 4) chk("t1_count_steady", 32'(count_o), 32'd4);
    end
    drain(4);
    chk("t1_count_drained", 32'(count_o), 32'd0);
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // 2: fill and stall, then release one word
    fill(8'hA0, 4);
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("t2_count_full", 32'(count_o), 32'd4);
    chk("t2_ready_full_stall", 32'(ready_o), 32'd0);
    chk("t2_data_head", 32'(data_o), 32'hA0);
    step();
    step();
    chk("t2_data_held", 32'(data_o), 32'hA0);
    chk("t2_valid_held", 32'(valid_o), 32'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    chk("t2_ready_full_go", 32'(ready_o), 32'd1);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("t2_next_word", 32'(data_o), 32'hA1);
    chk("t2_ready_after", 32'(ready_o), 32'd1);
    chk("t2_count_after", 32'(count_o), 32'd3);
    drain(3);
    chk("t2_count_drained", 32'(count_o), 32'd0);

    // 3: bubble collapse while stalled
    drive(1'b1, 8'h11, 1'b0, 1'b0); step();
    drive(1'b0, '0,    1'b0, 1'b0); step(); step();
    drive(1'b1, 8'h22, 1'b0, 1'b0); step();
    drive(1'b0, '0,    1'b0, 1'b0); step(); step();
    chk("t3_count", 32'(count_o), 32'd2);
    chk("t3_head", 32'(data_o), 32'h11);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    // 0x22 follows immediately, so it was packed right behind 0x11
    chk("t3_packed_valid", 32'(valid_o), 32'd1);
    chk("t3_packed_data", 32'(data_o), 32'h22);
    step();
    chk("t3_count_drained", 32'(count_o), 32'd0);

    // 4: full pipe, accept and emit every cycle
    fill(8'hB0, 4);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'hC0 + WIDTH'(i), 1'b1, 1'b0);
      #1;
      chk("t4_ready", 32'(ready_o), 32'd1);
      step();
      chk("t4_count", 32'(count_o), 32'd4);
    end
    drain(4);
    chk("t4_count_drained", 32'(count_o), 32'd0);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5: flush with 3 words and an incoming valid
    fill(8'hD0, 3);
    chk("t5_count_pre", 32'(count_o), 32'd3);
    drive(1'b1, 8'hDF, 1'b1, 1'b1);
    #1;
    chk("t5_ready_flush", 32'(ready_o), 32'd0);
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    chk("t5_valid_after", 32'(valid_o), 32'd0);
    chk("t5_count_after", 32'(count_o), 32'd0);
    chk("t5_ready_after", 32'(ready_o), 32'd1);
    step(); step(); step(); step();
    chk("t5_not_stored", 32'(valid_o), 32'd0);
    chk("t5_count_still", 32'(count_o), 32'd0);

    // 6: reset mid-stream
    fill(8'hE0, 3);
    chk("t6_count_pre", 32'(count_o), 32'd3);
    reset = 1'b1;
    drive(1'b1, 8'hE3, 1'b1, 1'b0);
    step();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("t6_valid", 32'(valid_o), 32'd0);
    chk("t6_data", 32'(data_o), 32'd0);
    chk("t6_count", 32'(count_o), 32'd0);
    chk("t6_ready", 32'(ready_o), 32'd1);
    drain(4);
    chk("t6_no_output", 32'(valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
